// File: rtl/idu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : idu_issue_ctrl                                                  |
// | Function : in-order issue stage with register scoreboard, SYSTEM-op        |
// |            serialization, flush and a saturating hazard-stall counter.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module idu_issue_ctrl #(
    parameter int REG_ADDRW = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,

    input  logic                 i_pre_valid,
    output logic                 o_pre_ready,
    input  logic [REG_ADDRW-1:0] i_rs1id,
    input  logic [REG_ADDRW-1:0] i_rs2id,
    input  logic [REG_ADDRW-1:0] i_rdid,
    input  logic                 i_rdwen,
    input  logic                 i_sysins,

    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    output logic [REG_ADDRW-1:0] o_rdid,
    output logic [REG_ADDRW-1:0] o_rs1id,
    output logic [REG_ADDRW-1:0] o_rs2id,
    output logic                 o_rdwen,
    output logic                 o_sysins,

    input  logic                 i_wb_valid,
    input  logic [REG_ADDRW-1:0] i_wb_rdid,
    input  logic                 i_wb_rdwen,
    input  logic                 i_wb_sys,

    input  logic                 i_flush,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_stall_cnt
);

    localparam int                   C_NUM_REGS = 2 ** REG_ADDRW;
    localparam logic [REG_ADDRW-1:0] C_X0       = '0;
    localparam logic [CNT_W-1:0]     C_CNT_MAX  = '1;

    localparam logic [1:0] C_ST_RUN   = 2'd0;
    localparam logic [1:0] C_ST_DRAIN = 2'd1;
    localparam logic [1:0] C_ST_SYS   = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [C_NUM_REGS-1:0] r_pending;
    logic [C_NUM_REGS-1:0] w_pending_nxt;

    logic                  r_post_valid;
    logic [REG_ADDRW-1:0]  r_rdid;
    logic [REG_ADDRW-1:0]  r_rs1id;
    logic [REG_ADDRW-1:0]  r_rs2id;
    logic                  r_rdwen;
    logic                  r_sysins;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic w_sb_haz;
    logic w_out_haz;
    logic w_hazard;
    logic w_slot_free;
    logic w_fsm_permit;
    logic w_pre_ready;
    logic w_accept;
    logic w_handoff;
    logic w_set_en;
    logic w_clr_en;
    logic w_stall;
    logic w_sys_retained;

    // Hazards look only at registered scoreboard state; a same-cycle writeback
    // does not release the stall until the following cycle.
    assign w_sb_haz = ((i_rs1id != C_X0) & r_pending[i_rs1id])
                    | ((i_rs2id != C_X0) & r_pending[i_rs2id])
                    | (i_rdwen & (i_rdid != C_X0) & r_pending[i_rdid]);

    assign w_out_haz = r_post_valid & r_rdwen & (r_rdid != C_X0)
                     & ((i_rs1id == r_rdid) | (i_rs2id == r_rdid)
                        | (i_rdwen & (i_rdid == r_rdid)));

    assign w_hazard    = w_sb_haz | w_out_haz;
    assign w_slot_free = ~r_post_valid | i_post_ready;
    assign w_pre_ready = w_slot_free & ~w_hazard & w_fsm_permit & ~i_flush;
    assign w_accept    = i_pre_valid & w_pre_ready;
    assign w_handoff   = r_post_valid & i_post_ready;
    assign w_set_en    = w_handoff & ~i_flush & r_rdwen & (r_rdid != C_X0);
    assign w_clr_en    = i_wb_valid & i_wb_rdwen;
    assign w_stall     = i_pre_valid & ~w_pre_ready & ~i_flush;

    // A flushed SYSTEM op that already left for EXU still owes its writeback.
    assign w_sys_retained = (r_state == C_ST_SYS) & ~(r_post_valid & r_sysins);

    always_comb begin
        w_fsm_permit = 1'b0;
        case (r_state)
            C_ST_RUN:   w_fsm_permit = ~i_sysins;
            C_ST_DRAIN: w_fsm_permit = ~(|r_pending) & ~r_post_valid;
            default:    w_fsm_permit = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_RUN: begin
                if (i_pre_valid & i_sysins) w_state_nxt = C_ST_DRAIN;
            end
            C_ST_DRAIN: begin
                if (w_accept) w_state_nxt = C_ST_SYS;
            end
            C_ST_SYS: begin
                if (i_wb_valid & i_wb_sys) w_state_nxt = C_ST_RUN;
            end
            default: w_state_nxt = C_ST_RUN;
        endcase
        if (i_flush & ~w_sys_retained) w_state_nxt = C_ST_RUN;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= C_ST_RUN;
        else          r_state <= w_state_nxt;
    end

    // Set and clear never target the same index: a pending rd blocks reissue.
    assign w_pending_nxt[0] = 1'b0;
    for (genvar gi = 1; gi < C_NUM_REGS; gi++) begin : g_sb
        assign w_pending_nxt[gi] =
            (w_set_en & (r_rdid == REG_ADDRW'(gi)))
          | (r_pending[gi] & ~(w_clr_en & (i_wb_rdid == REG_ADDRW'(gi))));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_pending <= '0;
        else          r_pending <= w_pending_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_post_valid <= 1'b0;
            r_rdid       <= '0;
            r_rs1id      <= '0;
            r_rs2id      <= '0;
            r_rdwen      <= 1'b0;
            r_sysins     <= 1'b0;
        end else if (i_flush) begin
            r_post_valid <= 1'b0;
        end else if (w_accept) begin
            r_post_valid <= 1'b1;
            r_rdid       <= i_rdid;
            r_rs1id      <= i_rs1id;
            r_rs2id      <= i_rs2id;
            r_rdwen      <= i_rdwen;
            r_sysins     <= i_sysins;
        end else if (i_post_ready) begin
            r_post_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != C_CNT_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign o_pre_ready  = w_pre_ready;
    assign o_post_valid = r_post_valid;
    assign o_rdid       = r_rdid;
    assign o_rs1id      = r_rs1id;
    assign o_rs2id      = r_rs2id;
    assign o_rdwen      = r_rdwen;
    assign o_sysins     = r_sysins;
    assign o_busy       = (|r_pending) | (r_state == C_ST_SYS);
    assign o_stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_idu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_idu_issue_ctrl                                               |
// | Function : directed scenarios plus randomized run against a reference model|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_idu_issue_ctrl;

    localparam int AW = 5;
    localparam int M_RUN = 0, M_DRAIN = 1, M_SYS = 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_pre_valid, i_rdwen, i_sysins, i_post_ready;
    logic [AW-1:0] i_rs1id, i_rs2id, i_rdid, i_wb_rdid;
    logic          i_wb_valid, i_wb_rdwen, i_wb_sys, i_flush;

    logic          o_pre_ready, o_post_valid, o_rdwen, o_sysins, o_busy;
    logic [AW-1:0] o_rdid, o_rs1id, o_rs2id;
    logic [15:0]   o_stall_cnt;

    logic          o4_pre_ready, o4_post_valid, o4_rdwen, o4_sysins, o4_busy;
    logic [AW-1:0] o4_rdid, o4_rs1id, o4_rs2id;
    logic [3:0]    o4_stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    idu_issue_ctrl #(.REG_ADDRW(AW), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
        .i_rs1id(i_rs1id), .i_rs2id(i_rs2id), .i_rdid(i_rdid),
        .i_rdwen(i_rdwen), .i_sysins(i_sysins),
        .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
        .o_rdid(o_rdid), .o_rs1id(o_rs1id), .o_rs2id(o_rs2id),
        .o_rdwen(o_rdwen), .o_sysins(o_sysins),
        .i_wb_valid(i_wb_valid), .i_wb_rdid(i_wb_rdid),
        .i_wb_rdwen(i_wb_rdwen), .i_wb_sys(i_wb_sys),
        .i_flush(i_flush), .o_busy(o_busy), .o_stall_cnt(o_stall_cnt)
    );

    idu_issue_ctrl #(.REG_ADDRW(AW), .CNT_W(4)) dut4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_pre_valid(i_pre_valid), .o_pre_ready(o4_pre_ready),
        .i_rs1id(i_rs1id), .i_rs2id(i_rs2id), .i_rdid(i_rdid),
        .i_rdwen(i_rdwen), .i_sysins(i_sysins),
        .o_post_valid(o4_post_valid), .i_post_ready(i_post_ready),
        .o_rdid(o4_rdid), .o_rs1id(o4_rs1id), .o_rs2id(o4_rs2id),
        .o_rdwen(o4_rdwen), .o_sysins(o4_sysins),
        .i_wb_valid(i_wb_valid), .i_wb_rdid(i_wb_rdid),
        .i_wb_rdwen(i_wb_rdwen), .i_wb_sys(i_wb_sys),
        .i_flush(i_flush), .o_busy(o4_busy), .o_stall_cnt(o4_stall_cnt)
    );

    // Reference model: set of registers with an outstanding write, one
    // output slot, an issue mode and an in-order queue of work inside EXU.
    typedef struct { int rd; bit rdwen; bit sys; } exu_t;
    exu_t exu_q[$];
    bit   m_pend[32];
    int   m_mode, m_rd, m_rs1, m_rs2, m_cnt, m_cnt4;
    bit   m_pv, m_rdwen, m_sys;

    function automatic bit conflicts(int idx);
        return idx != 0 && (m_pend[idx] || (m_pv && m_rdwen && m_rd == idx));
    endfunction

    function automatic bit any_pending();
        foreach (m_pend[k]) if (m_pend[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_ready();
        bit haz, perm;
        haz = conflicts(int'(i_rs1id)) || conflicts(int'(i_rs2id))
           || (i_rdwen && conflicts(int'(i_rdid)));
        case (m_mode)
            M_RUN:   perm = !i_sysins;
            M_DRAIN: perm = !any_pending() && !m_pv;
            default: perm = 1'b0;
        endcase
        return (!m_pv || i_post_ready) && !haz && perm && !i_flush;
    endfunction

    task automatic model_reset();
        foreach (m_pend[k]) m_pend[k] = 1'b0;
        exu_q.delete();
        m_mode = M_RUN; m_pv = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
        m_rdwen = 0; m_sys = 0; m_cnt = 0; m_cnt4 = 0;
    endtask

    task automatic model_step(output bit acc);
        bit rdy, ho;
        rdy = model_ready();
        acc = i_pre_valid && rdy;
        ho  = m_pv && i_post_ready && !i_flush;
        if (i_pre_valid && !rdy && !i_flush) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15)   m_cnt4++;
        end
        if (i_wb_valid && i_wb_rdwen) m_pend[int'(i_wb_rdid)] = 1'b0;
        if (ho) begin
            if (m_rdwen && m_rd != 0) m_pend[m_rd] = 1'b1;
            exu_q.push_back('{rd: m_rd, rdwen: m_rdwen, sys: m_sys});
        end
        if (i_flush) begin
            if (!(m_mode == M_SYS && !(m_pv && m_sys) && !(i_wb_valid && i_wb_sys)))
                m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (i_pre_valid && i_sysins) m_mode = M_DRAIN;
        end else if (m_mode == M_DRAIN) begin
            if (acc) m_mode = M_SYS;
        end else if (i_wb_valid && i_wb_sys) begin
            m_mode = M_RUN;
        end
        if (i_flush) m_pv = 0;
        else if (acc) begin
            m_pv = 1; m_rd = int'(i_rdid); m_rs1 = int'(i_rs1id); m_rs2 = int'(i_rs2id);
            m_rdwen = i_rdwen; m_sys = i_sysins;
        end else if (i_post_ready) m_pv = 0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_pre_valid = 0; i_rs1id = 0; i_rs2id = 0; i_rdid = 0; i_rdwen = 0;
        i_sysins = 0; i_post_ready = 0; i_wb_valid = 0; i_wb_rdid = 0;
        i_wb_rdwen = 0; i_wb_sys = 0; i_flush = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    task automatic set_instr(int rs1, int rs2, int rd, bit rdwen, bit sys);
        i_pre_valid = 1; i_rs1id = AW'(rs1); i_rs2id = AW'(rs2);
        i_rdid = AW'(rd); i_rdwen = rdwen; i_sysins = sys;
    endtask

    task automatic test_reset();
        do_reset();
        i_post_ready = 1;
        set_instr(1, 2, 5, 1, 0);
        tick(); tick();
        #1;
        n_checks++;
        if (o_busy !== 1'b1) $display("FAIL reset_pre_busy: got %b want 1", o_busy);
        else n_pass++;
        #1 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_post_valid, o_rdid, o_rs1id, o_rs2id, o_rdwen, o_sysins, o_busy, o_stall_cnt} !== '0)
            $display("FAIL reset_async: got rd=%0d rs1=%0d busy=%b cnt=%0d want all 0",
                     o_rdid, o_rs1id, o_busy, o_stall_cnt);
        else n_pass++;
        tick();
        n_checks++;
        if ({o_post_valid, o_rdid, o_busy, o_stall_cnt} !== '0)
            $display("FAIL reset_held: got pv=%b rd=%0d busy=%b cnt=%0d want all 0",
                     o_post_valid, o_rdid, o_busy, o_stall_cnt);
        else n_pass++;
        i_rst_n = 1'b1;
    endtask

    task automatic test_raw();
        do_reset();
        i_post_ready = 1;
        set_instr(1, 2, 5, 1, 0);
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b1) $display("FAIL raw_first_ready: got %b want 1", o_pre_ready);
        else n_pass++;
        tick();
        set_instr(5, 0, 6, 1, 0);
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b0) $display("FAIL raw_outreg_stall: got %b want 0", o_pre_ready);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL raw_sb_stall: got ready=%b busy=%b want 0/1", o_pre_ready, o_busy);
        else n_pass++;
        tick();
        i_wb_valid = 1; i_wb_rdid = 5; i_wb_rdwen = 1;
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b0) $display("FAIL raw_no_bypass: got %b want 0", o_pre_ready);
        else n_pass++;
        tick();
        i_wb_valid = 0;
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b1) $display("FAIL raw_release: got %b want 1", o_pre_ready);
        else n_pass++;
        tick();
        i_pre_valid = 0;
        #1;
        n_checks++;
        if (o_post_valid !== 1'b1 || o_rs1id !== 5'd5 || o_rdid !== 5'd6 || o_stall_cnt !== 16'd3)
            $display("FAIL raw_issued: got pv=%b rs1=%0d rd=%0d cnt=%0d want 1/5/6/3",
                     o_post_valid, o_rs1id, o_rdid, o_stall_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        i_post_ready = 1;
        set_instr(0, 0, 0, 1, 0);
        tick();
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b1) $display("FAIL x0_no_stall: got %b want 1", o_pre_ready);
        else n_pass++;
        tick();
        i_pre_valid = 0;
        tick(); tick();
        n_checks++;
        if (o_busy !== 1'b0 || o_stall_cnt !== 16'd0)
            $display("FAIL x0_sb_empty: got busy=%b cnt=%0d want 0/0", o_busy, o_stall_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_instr(1, 2, 3, 1, 0);
        tick();
        set_instr(4, 3, 9, 1, 0);
        repeat (3) tick();
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b0 || o_post_valid !== 1'b1 || o_rdid !== 5'd3)
            $display("FAIL b2b_held: got ready=%b pv=%b rd=%0d want 0/1/3",
                     o_pre_ready, o_post_valid, o_rdid);
        else n_pass++;
        i_post_ready = 1;
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b0) $display("FAIL b2b_handoff_stall: got %b want 0", o_pre_ready);
        else n_pass++;
        tick();
        i_wb_valid = 1; i_wb_rdid = 3; i_wb_rdwen = 1;
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b0 || o_post_valid !== 1'b0)
            $display("FAIL b2b_pending: got ready=%b pv=%b want 0/0", o_pre_ready, o_post_valid);
        else n_pass++;
        tick();
        i_wb_valid = 0;
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b1) $display("FAIL b2b_release: got %b want 1", o_pre_ready);
        else n_pass++;
        tick();
        i_pre_valid = 0;
        #1;
        n_checks++;
        if (o_post_valid !== 1'b1 || o_rs2id !== 5'd3 || o_rdid !== 5'd9)
            $display("FAIL b2b_issued: got pv=%b rs2=%0d rd=%0d want 1/3/9",
                     o_post_valid, o_rs2id, o_rdid);
        else n_pass++;
        tick();
    endtask

    task automatic test_serialize();
        do_reset();
        i_post_ready = 1;
        set_instr(0, 0, 7, 1, 0);
        tick();
        set_instr(0, 0, 0, 0, 1);
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b0) $display("FAIL ser_run_block: got %b want 0", o_pre_ready);
        else n_pass++;
        tick(); tick();
        n_checks++;
        if (o_pre_ready !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL ser_drain_wait: got ready=%b busy=%b want 0/1", o_pre_ready, o_busy);
        else n_pass++;
        i_wb_valid = 1; i_wb_rdid = 7; i_wb_rdwen = 1;
        tick();
        i_wb_valid = 0;
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b1) $display("FAIL ser_drain_release: got %b want 1", o_pre_ready);
        else n_pass++;
        tick();
        set_instr(1, 0, 2, 1, 0);
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b0 || o_sysins !== 1'b1 || o_post_valid !== 1'b1)
            $display("FAIL ser_sys_issued: got ready=%b sys=%b pv=%b want 0/1/1",
                     o_pre_ready, o_sysins, o_post_valid);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (o_pre_ready !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL ser_sys_block: got ready=%b busy=%b want 0/1", o_pre_ready, o_busy);
        else n_pass++;
        i_wb_valid = 1; i_wb_sys = 1; i_wb_rdwen = 0; i_wb_rdid = 0;
        tick();
        i_wb_valid = 0; i_wb_sys = 0;
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b1 || o_busy !== 1'b0)
            $display("FAIL ser_sys_retire: got ready=%b busy=%b want 1/0", o_pre_ready, o_busy);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        set_instr(0, 0, 4, 1, 0);
        tick();
        set_instr(1, 0, 2, 1, 0);
        i_flush = 1;
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", o_pre_ready);
        else n_pass++;
        tick();
        i_flush = 0; i_pre_valid = 0;
        #1;
        n_checks++;
        if (o_post_valid !== 1'b0 || o_stall_cnt !== 16'd0 || o_busy !== 1'b0)
            $display("FAIL flush_kill: got pv=%b cnt=%0d busy=%b want 0/0/0",
                     o_post_valid, o_stall_cnt, o_busy);
        else n_pass++;
        tick();
        set_instr(0, 0, 0, 0, 1);
        tick();
        tick();
        set_instr(1, 0, 2, 1, 0);
        i_flush = 1;
        tick();
        i_flush = 0;
        #1;
        n_checks++;
        if (o_pre_ready !== 1'b1 || o_busy !== 1'b0 || o_post_valid !== 1'b0)
            $display("FAIL flush_sys_outreg: got ready=%b busy=%b pv=%b want 1/0/0",
                     o_pre_ready, o_busy, o_post_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_saturation_reset();
        do_reset();
        i_post_ready = 1;
        set_instr(0, 0, 5, 1, 0);
        tick();
        set_instr(5, 0, 0, 0, 0);
        repeat (20) tick();
        #1;
        n_checks++;
        if (o4_stall_cnt !== 4'd15 || o_stall_cnt !== 16'd20 || o4_busy !== 1'b1)
            $display("FAIL sat_count: got cnt4=%0d cnt16=%0d busy=%b want 15/20/1",
                     o4_stall_cnt, o_stall_cnt, o4_busy);
        else n_pass++;
        #1 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o4_post_valid, o4_rdid, o4_rs1id, o4_rs2id, o4_rdwen, o4_sysins, o4_busy, o4_stall_cnt,
             o_busy, o_stall_cnt} !== '0)
            $display("FAIL sat_reset: got rd=%0d busy=%b cnt4=%0d cnt16=%0d want all 0",
                     o4_rdid, o4_busy, o4_stall_cnt, o_stall_cnt);
        else n_pass++;
        tick();
        i_rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_random(int cycles);
        bit have, acc, exp_rdy, exp_busy;
        int rs1, rs2, rd;
        bit rdwen, sys;
        exu_t e;
        do_reset();
        model_reset();
        have = 0;
        for (int c = 0; c < cycles; c++) begin
            if (!have) begin
                rs1 = $urandom_range(0, 7); rs2 = $urandom_range(0, 7); rd = $urandom_range(0, 7);
                rdwen = ($urandom_range(0, 9) < 7); sys = ($urandom_range(0, 9) == 0);
                have = 1;
            end
            set_instr(rs1, rs2, rd, rdwen, sys);
            i_pre_valid  = ($urandom_range(0, 3) != 0);
            i_post_ready = $urandom_range(0, 1);
            i_flush      = ($urandom_range(0, 24) == 0);
            if (exu_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                e = exu_q.pop_front();
                i_wb_valid = 1; i_wb_rdid = AW'(e.rd); i_wb_rdwen = e.rdwen; i_wb_sys = e.sys;
            end else begin
                i_wb_valid = 0; i_wb_rdid = AW'($urandom_range(0, 31));
                i_wb_rdwen = $urandom_range(0, 1); i_wb_sys = $urandom_range(0, 1);
            end
            #1;
            exp_rdy  = model_ready();
            exp_busy = any_pending() || m_mode == M_SYS;
            n_checks++;
            if (o_pre_ready !== exp_rdy)
                $display("FAIL rnd_pre_ready c%0d: got %b want %b", c, o_pre_ready, exp_rdy);
            else n_pass++;
            n_checks++;
            if (o_post_valid !== m_pv)
                $display("FAIL rnd_post_valid c%0d: got %b want %b", c, o_post_valid, m_pv);
            else n_pass++;
            n_checks++;
            if ({o_rdid, o_rs1id, o_rs2id, o_rdwen, o_sysins} !==
                {AW'(m_rd), AW'(m_rs1), AW'(m_rs2), m_rdwen, m_sys})
                $display("FAIL rnd_fields c%0d: got rd=%0d rs1=%0d rs2=%0d w=%b s=%b want %0d/%0d/%0d/%b/%b",
                         c, o_rdid, o_rs1id, o_rs2id, o_rdwen, o_sysins, m_rd, m_rs1, m_rs2, m_rdwen, m_sys);
            else n_pass++;
            n_checks++;
            if (o_busy !== exp_busy)
                $display("FAIL rnd_busy c%0d: got %b want %b", c, o_busy, exp_busy);
            else n_pass++;
            n_checks++;
            if (o_stall_cnt !== 16'(m_cnt) || o4_stall_cnt !== 4'(m_cnt4))
                $display("FAIL rnd_stall_cnt c%0d: got %0d/%0d want %0d/%0d",
                         c, o_stall_cnt, o4_stall_cnt, m_cnt, m_cnt4);
            else n_pass++;
            model_step(acc);
            if (acc || (i_flush && $urandom_range(0, 1) == 1)) have = 0;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_raw();
        test_x0();
        test_back_to_back();
        test_serialize();
        test_flush();
        test_saturation_reset();
        test_random(3000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
